eth_mdio_slave: RTL and testbench

- IEEE 802.3 Clause 22 MDIO management responder: the PHY-side end of the MDC/MDIO link that the Ethernet MAC framing block drives as initiator.
- Holds a 32 x 16-bit PHY register file and answers read and write frames addressed to its PHY address.
- Used as the PHY management model in FPGA loopback builds and in simulation benches for the RGMII Ethernet subsystem.
- MDC is treated as data, oversampled in the system clock domain.

---
 rtl/eth_mdio_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_eth_mdio_slave.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mdio_slave.sv
// eth_mdio_slave: Clause 22 MDIO responder (PHY side) with a 32 x 16-bit
// register file. MDC/MDIO are oversampled in the clk_i domain.
// Optional feature macro: ETH_MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
//   defined   -> a completed frame leaves the preamble counter full, so the
//                next frame may start directly with ST.
//   undefined -> every frame needs PRE_LEN preamble ones.
module eth_mdio_slave #(
  parameter logic [15:0] PHYID1  = 16'h0141,
  parameter logic [15:0] PHYID2  = 16'h0DD1,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  phy_addr_i,
  input  logic        link_up_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  output logic        reg_wr_o,
  output logic [4:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o,
  output logic        soft_rst_o
);

  localparam int unsigned    PCW      = $clog2(PRE_LEN + 1);
  localparam logic [PCW-1:0] PRE_FULL = PCW'(PRE_LEN);
  localparam logic [PCW-1:0] PRE_ZERO = {PCW{1'b0}};
`ifdef ETH_MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  localparam logic [PCW-1:0] PRE_AFTER = PRE_FULL;
`else
  localparam logic [PCW-1:0] PRE_AFTER = PRE_ZERO;
`endif

  typedef enum logic [2:0] {
    S_PRE  = 3'd0,
    S_ST   = 3'd1,
    S_OP   = 3'd2,
    S_ADDR = 3'd3,
    S_TA   = 3'd4,
    S_DATA = 3'd5
  } state_t;

  // Power-on / soft-reset contents of each register.
  function automatic logic [15:0] reset_val(input logic [4:0] a);
    case (a)
      5'd0:    reset_val = 16'h1140;
      5'd4:    reset_val = 16'h01E1;
      default: reset_val = 16'h0000;
    endcase
  endfunction

  // Read view: reg0 self-clearing reset bit, reg1 status, reg2/3 fixed IDs.
  function automatic logic [15:0] read_val(input logic [4:0] a, input logic [15:0] stored,
                                           input logic link);
    case (a)
      5'd0:    read_val = {1'b0, stored[14:0]};
      5'd1:    read_val = 16'h7969 | {13'b0, link, 2'b00};
      5'd2:    read_val = PHYID1;
      5'd3:    read_val = PHYID2;
      default: read_val = stored;
    endcase
  endfunction

  logic           r_mdc_s1, r_mdc_s2, r_mdc_d, r_mdio_s1, r_mdio_s2;
  state_t         r_state, w_state_nxt;
  logic [PCW-1:0] r_pre_cnt, w_pre_cnt_nxt;
  logic [3:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [15:0]    r_sh, w_sh_nxt;
  logic           r_is_rd, w_is_rd_nxt, r_match, w_match_nxt;
  logic [4:0]     r_regad, w_regad_nxt;
  logic           r_mdio_o, w_mdio_nxt, r_oe, w_oe_nxt;
  logic           r_reg_wr, r_soft;
  logic [4:0]     r_reg_addr;
  logic [15:0]    r_reg_wdata;
  logic [15:0]    r_regs [0:31];
  logic           w_edge, w_bit, w_commit, w_soft, w_drive;
  logic [15:0]    w_sh_in, w_snap;

  assign w_edge  = r_mdc_s2 & ~r_mdc_d;
  assign w_bit   = r_mdio_s2;
  assign w_sh_in = {r_sh[14:0], w_bit};
  assign w_snap  = read_val(w_sh_in[4:0], r_regs[w_sh_in[4:0]], link_up_i);
  assign w_drive = r_is_rd & r_match;

  assign mdio_o      = r_mdio_o;
  assign mdio_oe_o   = r_oe;
  assign reg_wr_o    = r_reg_wr;
  assign reg_addr_o  = r_reg_addr;
  assign reg_wdata_o = r_reg_wdata;
  assign soft_rst_o  = r_soft;

  // Two-flop synchronizers plus the previous-MDC flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mdc_s1 <= 1'b0; r_mdc_s2 <= 1'b0; r_mdc_d <= 1'b0;
      r_mdio_s1 <= 1'b0; r_mdio_s2 <= 1'b0;
    end else begin
      r_mdc_s1 <= mdc_i; r_mdc_s2 <= r_mdc_s1; r_mdc_d <= r_mdc_s2;
      r_mdio_s1 <= mdio_i; r_mdio_s2 <= r_mdio_s1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_PRE;
    else       r_state <= w_state_nxt;
  end

  // Next frame state, advanced only on detected MDC rising edges.
  always_comb begin
    w_state_nxt = r_state;
    if (w_edge) begin
      case (r_state)
        S_PRE:  if (!w_bit && (r_pre_cnt == PRE_FULL)) w_state_nxt = S_ST; else w_state_nxt = S_PRE;
        S_ST:   if (w_bit) w_state_nxt = S_OP; else w_state_nxt = S_PRE;
        S_OP:   if (r_bit_cnt == 4'd1) begin
                  if ((w_sh_in[1:0] == 2'b10) || (w_sh_in[1:0] == 2'b01)) w_state_nxt = S_ADDR;
                  else w_state_nxt = S_PRE;
                end else w_state_nxt = S_OP;
        S_ADDR: if (r_bit_cnt == 4'd9) w_state_nxt = S_TA; else w_state_nxt = S_ADDR;
        S_TA:   if (r_bit_cnt == 4'd1) w_state_nxt = S_DATA; else w_state_nxt = S_TA;
        S_DATA: if (r_bit_cnt == 4'd15) w_state_nxt = S_PRE; else w_state_nxt = S_DATA;
        default: w_state_nxt = S_PRE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Per-edge datapath: counters, shifting, match/snapshot, MDIO drive, commit.
  always_comb begin
    w_pre_cnt_nxt = r_pre_cnt; w_bit_cnt_nxt = r_bit_cnt; w_sh_nxt = r_sh;
    w_is_rd_nxt = r_is_rd; w_match_nxt = r_match; w_regad_nxt = r_regad;
    w_mdio_nxt = r_mdio_o; w_oe_nxt = r_oe; w_commit = 1'b0; w_soft = 1'b0;
    if (w_edge) begin
      w_bit_cnt_nxt = r_bit_cnt + 4'd1;
      case (r_state)
        S_PRE: begin
          w_bit_cnt_nxt = 4'd0;
          if (w_bit) begin
            if (r_pre_cnt != PRE_FULL) w_pre_cnt_nxt = r_pre_cnt + {{(PCW-1){1'b0}}, 1'b1};
            else w_pre_cnt_nxt = r_pre_cnt;
          end else if (r_pre_cnt != PRE_FULL) w_pre_cnt_nxt = PRE_ZERO;
          else w_pre_cnt_nxt = r_pre_cnt;
        end
        S_ST: begin
          w_bit_cnt_nxt = 4'd0;
          w_pre_cnt_nxt = PRE_ZERO;
        end
        S_OP: begin
          w_sh_nxt = w_sh_in;
          if (r_bit_cnt == 4'd1) begin
            w_bit_cnt_nxt = 4'd0;
            w_is_rd_nxt   = (w_sh_in[1:0] == 2'b10);
          end else w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end
        S_ADDR: begin
          w_sh_nxt = w_sh_in;
          if (r_bit_cnt == 4'd9) begin
            w_bit_cnt_nxt = 4'd0;
            w_match_nxt   = (w_sh_in[9:5] == phy_addr_i);
            w_regad_nxt   = w_sh_in[4:0];
            if (r_is_rd && (w_sh_in[9:5] == phy_addr_i)) w_sh_nxt = w_snap;
            else w_sh_nxt = w_sh_in;
          end else w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end
        S_TA: begin
          if (r_bit_cnt == 4'd0) begin
            if (w_drive) begin w_oe_nxt = 1'b1; w_mdio_nxt = 1'b0; end
            else w_oe_nxt = 1'b0;
          end else begin
            w_bit_cnt_nxt = 4'd0;
            if (w_drive) begin w_mdio_nxt = r_sh[15]; w_sh_nxt = {r_sh[14:0], 1'b0}; end
            else w_sh_nxt = r_sh;
          end
        end
        S_DATA: begin
          if (r_bit_cnt == 4'd15) begin
            w_bit_cnt_nxt = 4'd0;
            w_pre_cnt_nxt = PRE_AFTER;
            w_oe_nxt      = 1'b0;
            w_mdio_nxt    = 1'b0;
            w_commit      = r_match & ~r_is_rd;
            w_soft        = r_match & ~r_is_rd & (r_regad == 5'd0) & w_sh_in[15];
          end else if (w_drive) begin
            w_mdio_nxt = r_sh[15];
            w_sh_nxt   = {r_sh[14:0], 1'b0};
          end else w_sh_nxt = r_is_rd ? r_sh : w_sh_in;
          if ((r_bit_cnt == 4'd15) && !r_is_rd) w_sh_nxt = w_sh_in;
          else w_sh_nxt = w_sh_nxt;
        end
        default: begin
          w_bit_cnt_nxt = 4'd0;
          w_pre_cnt_nxt = PRE_ZERO;
        end
      endcase
    end else begin
      w_commit = 1'b0;
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre_cnt <= PRE_ZERO; r_bit_cnt <= 4'd0; r_sh <= 16'h0000;
      r_is_rd <= 1'b0; r_match <= 1'b0; r_regad <= 5'd0;
    end else begin
      r_pre_cnt <= w_pre_cnt_nxt; r_bit_cnt <= w_bit_cnt_nxt; r_sh <= w_sh_nxt;
      r_is_rd <= w_is_rd_nxt; r_match <= w_match_nxt; r_regad <= w_regad_nxt;
    end
  end

  // Registered outputs: MDIO drive, write strobe and last-write capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mdio_o <= 1'b0; r_oe <= 1'b0; r_reg_wr <= 1'b0; r_soft <= 1'b0;
      r_reg_addr <= 5'd0; r_reg_wdata <= 16'h0000;
    end else begin
      r_mdio_o <= w_mdio_nxt; r_oe <= w_oe_nxt; r_reg_wr <= w_commit; r_soft <= w_soft;
      if (w_commit) begin
        r_reg_addr  <= r_regad;
        r_reg_wdata <= w_sh_in;
      end
    end
  end

  // Register file; BMCR soft reset restores everything in the commit cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_soft) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= reset_val(5'(i));
    end else if (w_commit && !((r_regad >= 5'd1) && (r_regad <= 5'd3))) begin
      r_regs[r_regad] <= w_sh_in;
    end
  end

endmodule

// File: tb/tb_eth_mdio_slave.sv
// Scoreboard bench for eth_mdio_slave: directed test-plan frames plus
// randomized frames, checked against a register-level reference model.
`timescale 1ns/1ps
module tb_eth_mdio_slave;

  localparam int         PRE_LEN  = 32;
  localparam logic [4:0] PHY_ADDR = 5'd5;

  logic clk_i = 1'b0, rst_i = 1'b1, link_up_i = 1'b0, mdc_i = 1'b0, mdio_i = 1'b1;
  logic [4:0]  phy_addr_i = PHY_ADDR;
  logic        mdio_o, mdio_oe_o, reg_wr_o, soft_rst_o;
  logic [4:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;

  eth_mdio_slave dut (
    .clk_i(clk_i), .rst_i(rst_i), .phy_addr_i(phy_addr_i), .link_up_i(link_up_i),
    .mdc_i(mdc_i), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o),
    .reg_wr_o(reg_wr_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .soft_rst_o(soft_rst_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [4:0] a; logic [15:0] d; logic s; } wr_t;
  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  int n_checks = 0, n_fail = 0;
  int m_carry = 0;
  logic [15:0] m_regs [0:31];

`ifdef ETH_MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  localparam bit SUPP = 1'b1;
`else
  localparam bit SUPP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
    m_regs[0] = 16'h1140;
    m_regs[4] = 16'h01E1;
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] a);
    if (a == 5'd0)      return m_regs[0] & 16'h7FFF;
    else if (a == 5'd1) return 16'h7969 | (link_up_i ? 16'h0004 : 16'h0000);
    else if (a == 5'd2) return 16'h0141;
    else if (a == 5'd3) return 16'h0DD1;
    else                return m_regs[a];
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0 && d[15]) m_reset();
    else if (a >= 5'd1 && a <= 5'd3) begin end
    else m_regs[a] = d;
  endtask

  // One MDIO frame from the initiator; rst_at > 0 pulses rst_i after that edge.
  task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phyad,
                       input logic [4:0] regad, input logic [15:0] wd, input int rst_at);
    bit q[$];
    bit acc, vop, act;
    wr_t w;
    acc = (pre_len + m_carry) >= PRE_LEN;
    vop = (op == 2'b10) || (op == 2'b01);
    act = acc && vop && (phyad == PHY_ADDR) && (rst_at == 0);
    if (act && op == 2'b10) exp_rd.push_back(m_read(regad));
    if (act && op == 2'b01) begin
      w.a = regad; w.d = wd; w.s = (regad == 5'd0) && wd[15];
      exp_wr.push_back(w);
      m_write(regad, wd);
    end
    for (int i = 0; i < pre_len; i++) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(1'b1);
    q.push_back(op[1]); q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(phyad[i]);
    for (int i = 4; i >= 0; i--) q.push_back(regad[i]);
    q.push_back(1'b1); q.push_back(op == 2'b10 ? 1'b1 : 1'b0);
    for (int i = 15; i >= 0; i--) q.push_back(op == 2'b10 ? 1'b1 : wd[i]);
    for (int i = 0; i < q.size(); i++) begin
      mdc_i = 1'b0; mdio_i = q[i];
      repeat (4) @(negedge clk_i);
      mdc_i = 1'b1;
      repeat (4) @(negedge clk_i);
      if (rst_at != 0 && (i - pre_len + 1) == rst_at) begin
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("oe_after_rst", {31'd0, mdio_oe_o}, 32'd0);
        chk("wr_after_rst", {31'd0, reg_wr_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        m_reset();
        m_carry = 0;
        mdc_i = 1'b0; mdio_i = 1'b1;
        repeat (8) @(negedge clk_i);
        return;
      end
    end
    mdc_i = 1'b0; mdio_i = 1'b1;
    repeat (8) @(negedge clk_i);
    chk("oe_idle", {31'd0, mdio_oe_o}, 32'd0);
    m_carry = (acc && vop && SUPP) ? PRE_LEN : 0;
  endtask

  // Read monitor: collects the driven bits at each MDC rise, compares on OE drop.
  logic        mdc_prev = 1'b0;
  bit          rd_coll = 1'b0;
  int          rd_bits = 0;
  logic [16:0] rd_acc = 17'd0;
  always @(negedge clk_i) begin
    logic [15:0] e;
    if (rst_i) begin
      rd_coll = 1'b0; rd_bits = 0; rd_acc = 17'd0;
    end else if (mdio_oe_o) begin
      rd_coll = 1'b1;
      if (mdc_i && !mdc_prev) begin
        rd_acc = {rd_acc[15:0], mdio_o};
        rd_bits++;
      end
    end else if (rd_coll) begin
      if (exp_rd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_unexpected actual=%h required=no_response", rd_acc);
      end else begin
        e = exp_rd.pop_front();
        chk("rd_bitcount", rd_bits, 32'd17);
        chk("rd_data", {15'd0, rd_acc}, {15'd0, 1'b0, e});
      end
      rd_coll = 1'b0; rd_bits = 0; rd_acc = 17'd0;
    end
    mdc_prev = mdc_i;
  end

  // Write monitor: each reg_wr_o pulse must match the next expected commit.
  always @(negedge clk_i) begin
    wr_t w;
    if (!rst_i && soft_rst_o && !reg_wr_o) begin
      n_checks++; n_fail++;
      $display("FAIL soft_without_wr actual=1 required=0");
    end
    if (!rst_i && reg_wr_o) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_unexpected actual=%h:%h required=no_write", reg_addr_o, reg_wdata_o);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", {27'd0, reg_addr_o}, {27'd0, w.a});
        chk("wr_data", {16'd0, reg_wdata_o}, {16'd0, w.d});
        chk("wr_soft", {31'd0, soft_rst_o}, {31'd0, w.s});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    int sel;
    m_reset();
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
    chk("rst_oe", {31'd0, mdio_oe_o}, 32'd0);
    chk("rst_wr", {31'd0, reg_wr_o}, 32'd0);
    chk("rst_addr", {27'd0, reg_addr_o}, 32'd0);
    chk("rst_wdata", {16'd0, reg_wdata_o}, 32'd0);
    chk("rst_soft", {31'd0, soft_rst_o}, 32'd0);

    frame(32, 2'b10, 5'd5, 5'd2, 16'h0000, 0);   // PHYID1
    frame(32, 2'b01, 5'd5, 5'd4, 16'h05E1, 0);
    frame(32, 2'b10, 5'd5, 5'd4, 16'h0000, 0);
    frame(32, 2'b10, 5'd6, 5'd2, 16'h0000, 0);   // wrong PHY
    frame(32, 2'b01, 5'd6, 5'd4, 16'hBEEF, 0);
    frame(32, 2'b10, 5'd5, 5'd4, 16'h0000, 0);
    frame(31, 2'b10, 5'd5, 5'd2, 16'h0000, 0);   // short preamble
    frame(32, 2'b10, 5'd5, 5'd2, 16'h0000, 0);
    frame(32, 2'b01, 5'd5, 5'd0, 16'h8000, 0);   // BMCR soft reset
    frame(32, 2'b10, 5'd5, 5'd4, 16'h0000, 0);
    frame(32, 2'b10, 5'd5, 5'd0, 16'h0000, 0);
    link_up_i = 1'b1;
    frame(32, 2'b10, 5'd5, 5'd1, 16'h0000, 0);
    link_up_i = 1'b0;
    frame(32, 2'b10, 5'd5, 5'd1, 16'h0000, 0);
    frame(32, 2'b01, 5'd5, 5'd3, 16'h1234, 0);   // read-only write
    frame(32, 2'b10, 5'd5, 5'd3, 16'h0000, 0);
    frame(32, 2'b00, 5'd5, 5'd4, 16'h0F0F, 0);   // invalid opcodes
    frame(32, 2'b11, 5'd5, 5'd4, 16'h0F0F, 0);

    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 9);
      op  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b11 : (sel < 6) ? 2'b10 : 2'b01;
      link_up_i = 1'($urandom_range(0, 1));
      frame(32 + $urandom_range(0, 3), op,
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY_ADDR,
            5'($urandom), 16'($urandom), 0);
    end

    frame(32, 2'b01, 5'd5, 5'd4, 16'h1234, 0);
    frame(32, 2'b10, 5'd5, 5'd2, 16'h0000, 20);  // reset mid-read
    frame(32, 2'b10, 5'd5, 5'd4, 16'h0000, 0);   // back at reset value
    frame(32, 2'b10, 5'd5, 5'd2, 16'h0000, 0);

    repeat (20) @(negedge clk_i);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
